// File: rtl/obstacle_render_pipeline.sv
// Three-stage textured obstacle pixel pipeline: texel addressing, external texture ROM
// lookup, and palette resolve, with frame-driven texture animation.
module obstacle_render_pipeline #(
  parameter int TEX_NUM         = 4,
  parameter int OBSTACLE_WIDTH  = 10,
  parameter int OBSTACLE_HEIGHT = 2 * OBSTACLE_WIDTH,
  parameter int SCREEN_WIDTH    = 10,
  parameter int PHY_WIDTH       = 15,
  parameter int PIXEL_WIDTH     = 12,
  parameter int COLOR_WIDTH     = 2,
  parameter int ID_WIDTH        = 4,
  parameter int ANIM_PERIOD     = 30,
  localparam int TEX_SEL_W      = $clog2(TEX_NUM),
  localparam int TEX_ADDR_W     = $clog2(OBSTACLE_WIDTH * OBSTACLE_WIDTH),
  localparam int PAL_ADDR_W     = TEX_SEL_W + COLOR_WIDTH
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    pix_valid,
  input  logic                    obstacle_on,
  input  logic [1:0]              obstacle_face,
  input  logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  input  logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  input  logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  input  logic [ID_WIDTH-1:0]     obstacle_on_id,
  input  logic                    frame_start,
  input  logic                    anim_en,
  output logic [TEX_SEL_W-1:0]    tex_sel,
  output logic [TEX_ADDR_W-1:0]   tex_addr,
  input  logic [COLOR_WIDTH-1:0]  tex_idx,
  input  logic                    pal_we,
  input  logic [PAL_ADDR_W-1:0]   pal_addr,
  input  logic [PIXEL_WIDTH-1:0]  pal_wdata,
  output logic [PIXEL_WIDTH-1:0]  rgb,
  output logic                    rgb_valid,
  output logic                    rgb_hit
);

  localparam int PAL_DEPTH = TEX_NUM << COLOR_WIDTH;
  localparam int FRAME_W   = $clog2(ANIM_PERIOD);

  logic [FRAME_W-1:0]     r_frame_cnt;
  logic [TEX_SEL_W-1:0]   r_anim_ofs;
  logic                   r_s1_valid, r_s1_on;
  logic                   r_s2_valid, r_s2_on;
  logic [TEX_SEL_W-1:0]   r_s2_sel;
  logic [COLOR_WIDTH-1:0] r_s2_idx;
  logic [PIXEL_WIDTH-1:0] r_pal [PAL_DEPTH];

  logic [SCREEN_WIDTH-1:0] w_x_mod, w_x_tex, w_y_tex;
  logic [PHY_WIDTH:0]      w_sel_sum, w_sel_mod;
  logic                    w_s2_hit;

  function automatic logic [PIXEL_WIDTH-1:0] pal_default(input int idx);
    case (idx % (1 << COLOR_WIDTH))
      0:       return PIXEL_WIDTH'(12'h444);
      1:       return PIXEL_WIDTH'(12'h222);
      2:       return PIXEL_WIDTH'(12'h000);
      3:       return PIXEL_WIDTH'(12'h140);
      default: return '0;
    endcase
  endfunction

  // (y mod 2W) >> 1 is identical to (y >> 1) mod W because the texture is twice as tall as wide.
  assign w_x_mod   = obstacle_x_rom % SCREEN_WIDTH'(OBSTACLE_WIDTH);
  assign w_x_tex   = (obstacle_face == 2'b01) ? w_x_mod
                                              : SCREEN_WIDTH'(OBSTACLE_WIDTH - 1) - w_x_mod;
  assign w_y_tex   = (obstacle_y_rom % SCREEN_WIDTH'(OBSTACLE_HEIGHT)) >> 1;
  assign w_sel_sum = (PHY_WIDTH+1)'(obstacle_abs_pos_y) + (PHY_WIDTH+1)'(obstacle_on_id)
                   + (PHY_WIDTH+1)'(r_anim_ofs);
  assign w_sel_mod = w_sel_sum % (PHY_WIDTH+1)'(TEX_NUM);
  assign w_s2_hit  = r_s2_valid & r_s2_on;

  // Animation state; a request sampled on the same edge as a pulse still sees the old offset.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_frame_cnt <= '0;
      r_anim_ofs  <= '0;
    end else if (frame_start && anim_en) begin
      if (r_frame_cnt == FRAME_W'(ANIM_PERIOD - 1)) begin
        r_frame_cnt <= '0;
        r_anim_ofs  <= (r_anim_ofs == TEX_SEL_W'(TEX_NUM - 1)) ? '0 : r_anim_ofs + 1'b1;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // Stage 1: texture ROM request.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_on    <= 1'b0;
      tex_sel    <= '0;
      tex_addr   <= '0;
    end else begin
      r_s1_valid <= pix_valid;
      r_s1_on    <= obstacle_on;
      tex_sel    <= (&obstacle_on_id) ? '0 : TEX_SEL_W'(w_sel_mod);
      tex_addr   <= TEX_ADDR_W'(w_y_tex) * TEX_ADDR_W'(OBSTACLE_WIDTH) + TEX_ADDR_W'(w_x_tex);
    end
  end

  // Stage 2: capture ROM data alongside the carried request attributes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_s2_valid <= 1'b0;
      r_s2_on    <= 1'b0;
      r_s2_sel   <= '0;
      r_s2_idx   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_on    <= r_s1_on;
      r_s2_sel   <= tex_sel;
      r_s2_idx   <= tex_idx;
    end
  end

  // NOTE: the palette is a register file, so it can be reloaded by reset; a RAM macro could not.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < PAL_DEPTH; i++) r_pal[i] <= pal_default(i);
    end else if (pal_we) begin
      r_pal[pal_addr] <= pal_wdata;
    end
  end

  // NOTE: non-blocking updates make a same-edge read of a written entry return the old value.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rgb       <= '0;
      rgb_valid <= 1'b0;
      rgb_hit   <= 1'b0;
    end else begin
      rgb_valid <= r_s2_valid;
      rgb_hit   <= w_s2_hit;
      rgb       <= w_s2_hit ? r_pal[{r_s2_sel, r_s2_idx}] : '0;
    end
  end

endmodule

// File: tb/tb_obstacle_render_pipeline.sv
// Self-checking bench for obstacle_render_pipeline: directed vector table, corner sequences,
// and a randomized stream scored against an arithmetic reference model.
module tb_obstacle_render_pipeline;

  localparam int TEX_NUM = 4, W = 10, SW = 10, PHY = 15, PIX = 12, CW = 2, IDW = 4, ANIM = 30;
  localparam int TSW = $clog2(TEX_NUM), AW = $clog2(W * W), PAW = TSW + CW;
  localparam int NCYC = 300;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic           pix_valid, obstacle_on, frame_start, anim_en, pal_we;
  logic [1:0]     obstacle_face;
  logic [SW-1:0]  obstacle_x_rom, obstacle_y_rom;
  logic [PHY-1:0] obstacle_abs_pos_y;
  logic [IDW-1:0] obstacle_on_id;
  logic [TSW-1:0] tex_sel;
  logic [AW-1:0]  tex_addr;
  logic [CW-1:0]  tex_idx;
  logic [PAW-1:0] pal_addr;
  logic [PIX-1:0] pal_wdata, rgb;
  logic           rgb_valid, rgb_hit;

  logic           rom_force;
  logic [CW-1:0]  rom_force_val;

  int total = 0;
  int bad   = 0;

  int mpal [TEX_NUM << CW];
  int pulses;

  typedef struct {
    logic       valid;
    logic       on;
    logic [1:0] face;
    int         x, y, abs_y, id, idx;
    int         exp_addr, exp_sel, exp_rgb;
    logic       exp_hit;
  } vec_t;

  vec_t vecs [7];

  obstacle_render_pipeline dut (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .pix_valid          (pix_valid),
    .obstacle_on        (obstacle_on),
    .obstacle_face      (obstacle_face),
    .obstacle_x_rom     (obstacle_x_rom),
    .obstacle_y_rom     (obstacle_y_rom),
    .obstacle_abs_pos_y (obstacle_abs_pos_y),
    .obstacle_on_id     (obstacle_on_id),
    .frame_start        (frame_start),
    .anim_en            (anim_en),
    .tex_sel            (tex_sel),
    .tex_addr           (tex_addr),
    .tex_idx            (tex_idx),
    .pal_we             (pal_we),
    .pal_addr           (pal_addr),
    .pal_wdata          (pal_wdata),
    .rgb                (rgb),
    .rgb_valid          (rgb_valid),
    .rgb_hit            (rgb_hit)
  );

  always #5 sys_clk = ~sys_clk;

  // Texture ROM stand-in: arbitrary but deterministic content, answering the current request.
  function automatic logic [CW-1:0] rom_fn(input logic [TSW-1:0] s, input logic [AW-1:0] a);
    return a[1:0] ^ a[3:2] ^ a[5:4] ^ s;
  endfunction

  assign tex_idx = rom_force ? rom_force_val : rom_fn(tex_sel, tex_addr);

  function automatic int m_addr(input int face, input int x, input int y);
    int xt;
    xt = (face == 1) ? (x % W) : (W - 1 - (x % W));
    return ((y / 2) % W) * W + xt;
  endfunction

  function automatic int m_sel(input int abs_y, input int id, input int ofs);
    return (id == (1 << IDW) - 1) ? 0 : (abs_y + id + ofs) % TEX_NUM;
  endfunction

  function automatic int m_ofs();
    return (pulses / ANIM) % TEX_NUM;
  endfunction

  task automatic m_pal_reset();
    int dflt [4] = '{'h444, 'h222, 'h000, 'h140};
    for (int t = 0; t < TEX_NUM; t++)
      for (int i = 0; i < 4; i++) mpal[t * 4 + i] = dflt[i];
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    pix_valid = 0; obstacle_on = 0; obstacle_face = 2'b01;
    obstacle_x_rom = '0; obstacle_y_rom = '0; obstacle_abs_pos_y = '0; obstacle_on_id = '0;
    frame_start = 0; anim_en = 0; pal_we = 0; pal_addr = '0; pal_wdata = '0;
  endtask

  task automatic drive_req(input logic v, input logic on, input logic [1:0] face,
                           input int x, input int y, input int abs_y, input int id);
    pix_valid = v; obstacle_on = on; obstacle_face = face;
    obstacle_x_rom = SW'(x); obstacle_y_rom = SW'(y);
    obstacle_abs_pos_y = PHY'(abs_y); obstacle_on_id = IDW'(id);
  endtask

  // Called on a negedge; returns on the negedge after the result is registered.
  task automatic run_req(input vec_t v, input string tag);
    drive_req(v.valid, v.on, v.face, v.x, v.y, v.abs_y, v.id);
    rom_force = 1; rom_force_val = CW'(v.idx);
    @(posedge sys_clk); @(negedge sys_clk);
    check({tag, ".tex_addr"}, 32'(tex_addr), v.exp_addr);
    check({tag, ".tex_sel"},  32'(tex_sel),  v.exp_sel);
    idle();
    @(posedge sys_clk); @(posedge sys_clk); @(negedge sys_clk);
    check({tag, ".rgb_valid"}, 32'(rgb_valid), 32'(v.valid));
    check({tag, ".rgb_hit"},   32'(rgb_hit),   32'(v.exp_hit));
    check({tag, ".rgb"},       32'(rgb),       v.exp_rgb);
    rom_force = 0;
  endtask

  task automatic sel_probe(input int exp, input string tag);
    drive_req(1, 0, 2'b01, 0, 0, 0, 0);
    @(posedge sys_clk); @(negedge sys_clk);
    check(tag, 32'(tex_sel), exp);
    idle();
  endtask

  task automatic pulse_frames(input int n, input logic en);
    repeat (n) begin
      frame_start = 1; anim_en = en;
      @(posedge sys_clk); @(negedge sys_clk);
      frame_start = 0; anim_en = 0;
    end
  endtask

  int   e_sel [NCYC], e_addr [NCYC], e_rgb [NCYC];
  logic e_valid [NCYC], e_on [NCYC];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t pv;
    //          valid on   face   x     y     abs    id  idx  addr sel rgb    hit
    vecs[0] = '{1'b1, 1'b1, 2'b01, 3,    7,    5,     2,  3,   33,  3,  'h140, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 0,    0,    0,     0,  1,   9,   0,  'h222, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 12,   0,    1,     0,  0,   7,   1,  'h444, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 5,    40,   7,     15, 2,   5,   0,  'h000, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'b00, 19,   39,   32767, 14, 3,   90,  1,  'h140, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 2'b11, 1023, 1023, 100,   3,  0,   16,  3,  'h444, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'b01, 2,    2,    2,     1,  3,   12,  3,  'h000, 1'b0};

    idle();
    rom_force = 0; rom_force_val = '0;
    pulses = 0;
    m_pal_reset();
    sys_rst = 1;
    #12;
    @(negedge sys_clk);
    sys_rst = 0;
    check("reset.tex_sel",   32'(tex_sel),   0);
    check("reset.tex_addr",  32'(tex_addr),  0);
    check("reset.rgb",       32'(rgb),       0);
    check("reset.rgb_valid", 32'(rgb_valid), 0);
    check("reset.rgb_hit",   32'(rgb_hit),   0);

    for (int i = 0; i < 7; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Palette write landing on the same edge as a stage-3 read of that entry.
    drive_req(1, 1, 2'b01, 0, 0, 1, 0);
    rom_force = 1; rom_force_val = 2'd1;
    @(posedge sys_clk); @(negedge sys_clk);
    idle();
    @(posedge sys_clk); @(negedge sys_clk);
    pal_we = 1; pal_addr = PAW'(5); pal_wdata = 12'hF00;
    @(posedge sys_clk); @(negedge sys_clk);
    pal_we = 0;
    mpal[5] = 'hF00;
    check("pal_same_cycle.rgb", 32'(rgb), 'h222);
    check("pal_same_cycle.hit", 32'(rgb_hit), 1);
    pv = '{1'b1, 1'b1, 2'b01, 0, 0, 1, 0, 1, 0, 1, 'hF00, 1'b1};
    run_req(pv, "pal_after_write");

    // Reset with two pixels in flight.
    drive_req(1, 1, 2'b01, 0, 0, 1, 0);
    rom_force = 1; rom_force_val = 2'd1;
    @(posedge sys_clk); @(negedge sys_clk);
    drive_req(1, 1, 2'b01, 5, 0, 1, 0);
    @(posedge sys_clk);
    #2 sys_rst = 1;
    #1;
    check("midrst.tex_sel",   32'(tex_sel),   0);
    check("midrst.tex_addr",  32'(tex_addr),  0);
    check("midrst.rgb_valid", 32'(rgb_valid), 0);
    @(negedge sys_clk);
    sys_rst = 0;
    idle();
    m_pal_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge sys_clk); @(negedge sys_clk);
      check($sformatf("midrst.drain%0d", i), 32'(rgb_valid), 0);
    end
    drive_req(1, 1, 2'b01, 0, 0, 1, 0);
    @(posedge sys_clk); @(negedge sys_clk);
    idle();
    @(posedge sys_clk); @(negedge sys_clk);
    check("midrst.latency2", 32'(rgb_valid), 0);
    @(posedge sys_clk); @(negedge sys_clk);
    check("midrst.latency3", 32'(rgb_valid), 1);
    check("midrst.pal_default", 32'(rgb), 'h222);
    rom_force = 0;

    // Animation: 30 counted pulses per step, hold when disabled, wrap after 120.
    pulse_frames(29, 1'b1);
    sel_probe(0, "anim.after29");
    drive_req(1, 0, 2'b01, 0, 0, 0, 0);
    frame_start = 1; anim_en = 1;
    @(posedge sys_clk); @(negedge sys_clk);
    check("anim.coincident_pre", 32'(tex_sel), 0);
    idle();
    sel_probe(1, "anim.after30");
    pulse_frames(30, 1'b0);
    sel_probe(1, "anim.hold_disabled");
    pulse_frames(60, 1'b1);
    sel_probe(3, "anim.after90");
    pulse_frames(30, 1'b1);
    sel_probe(0, "anim.wrap120");

    // Randomized stream against the reference model (animation back at offset 0, count 0).
    pulses = 0;
    for (int c = 0; c < NCYC + 3; c++) begin
      if (c >= 1 && c - 1 < NCYC) begin
        check($sformatf("rnd.tex_sel[%0d]", c - 1),  32'(tex_sel),  e_sel[c - 1]);
        check($sformatf("rnd.tex_addr[%0d]", c - 1), 32'(tex_addr), e_addr[c - 1]);
      end
      if (c >= 3) begin
        check($sformatf("rnd.rgb_valid[%0d]", c - 3), 32'(rgb_valid), 32'(e_valid[c - 3]));
        check($sformatf("rnd.rgb_hit[%0d]", c - 3),   32'(rgb_hit),
              32'(e_valid[c - 3] & e_on[c - 3]));
        check($sformatf("rnd.rgb[%0d]", c - 3),       32'(rgb),       e_rgb[c - 3]);
      end
      if (c >= 2 && c - 2 < NCYC) begin
        int k, idx;
        k   = c - 2;
        idx = int'(rom_fn(TSW'(e_sel[k]), AW'(e_addr[k])));
        e_rgb[k] = (e_valid[k] && e_on[k]) ? mpal[e_sel[k] * 4 + idx] : 0;
      end
      if (c < NCYC) begin
        int x, y, ab, id, face;
        x    = int'($urandom_range(0, 1023));
        y    = int'($urandom_range(0, 1023));
        ab   = int'($urandom_range(0, 32767));
        id   = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 15));
        face = int'($urandom_range(0, 3));
        e_valid[c] = ($urandom_range(0, 3) != 0);
        e_on[c]    = ($urandom_range(0, 4) < 3);
        drive_req(e_valid[c], e_on[c], 2'(face), x, y, ab, id);
        e_addr[c] = m_addr(face, x, y);
        e_sel[c]  = m_sel(ab, id, m_ofs());
        frame_start = $urandom_range(0, 1) == 1;
        anim_en     = $urandom_range(0, 4) != 0;
        pal_we      = $urandom_range(0, 4) == 0;
        pal_addr    = PAW'($urandom_range(0, (1 << PAW) - 1));
        pal_wdata   = PIX'($urandom_range(0, (1 << PIX) - 1));
      end else begin
        idle();
      end
      if (frame_start && anim_en) pulses++;
      if (pal_we) mpal[int'(pal_addr)] = int'(pal_wdata);
      @(posedge sys_clk); @(negedge sys_clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obstacle_render_pipeline.md
OBSTACLE_RENDER_PIPELINE -- requirements
Module: obstacle_render_pipeline

Interface
REQ-001 SHALL have parameter TEX_NUM, default 4, meaning the number of wall textures.
REQ-002 SHALL have parameter OBSTACLE_WIDTH, default 10, meaning the texture width in texels; OBSTACLE_HEIGHT, default 20, SHALL equal 2*OBSTACLE_WIDTH.
REQ-003 SHALL have parameters SCREEN_WIDTH 10, PHY_WIDTH 15, PIXEL_WIDTH 12, COLOR_WIDTH 2 (colour indices per texture), ID_WIDTH 4, ANIM_PERIOD 30 (frames per animation step).
REQ-004 Port sys_clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-005 Port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port pix_valid, input, 1 bit: a pixel request is present this cycle.
REQ-007 Port obstacle_on, input, 1 bit: the pixel lies inside an obstacle.
REQ-008 Port obstacle_face, input, 2 bits: 2'b01 means unmirrored; any other value means mirrored in x.
REQ-009 Port obstacle_x_rom / obstacle_y_rom, input, SCREEN_WIDTH bits each: offset of the pixel within the obstacle.
REQ-010 Port obstacle_abs_pos_y, input, PHY_WIDTH bits: absolute obstacle row; obstacle_on_id, input, ID_WIDTH bits: obstacle index, where all-ones means none.
REQ-011 Port frame_start, input, 1 bit: one-cycle pulse per video frame; anim_en, input, 1 bit: enables animation.
REQ-012 Port tex_sel, output, clog2(TEX_NUM) bits, and tex_addr, output, clog2(OBSTACLE_WIDTH*OBSTACLE_WIDTH) bits: external texture ROM request.
REQ-013 Port tex_idx, input, COLOR_WIDTH bits: ROM data, valid exactly one cycle after tex_sel/tex_addr.
REQ-014 Port pal_we, input, 1 bit; pal_addr, input, clog2(TEX_NUM)+COLOR_WIDTH bits; pal_wdata, input, PIXEL_WIDTH bits: palette write port.
REQ-015 Port rgb, output, PIXEL_WIDTH bits; rgb_valid, output, 1 bit; rgb_hit, output, 1 bit (the obstacle pixel was drawn).

Function
REQ-016 SHALL be a 3-stage pipeline: a request at edge N yields rgb/rgb_valid/rgb_hit registered at edge N+3, accepting one request per cycle with no stalls.
REQ-017 Stage 1 x_tex SHALL be x mod W when face==2'b01, else (W-1-(x mod W)), where W=OBSTACLE_WIDTH; y_tex SHALL be (y>>1) mod W.
REQ-018 Stage 1 SHALL register tex_addr = y_tex*W + x_tex.
REQ-019 Stage 1 SHALL register tex_sel = 0 when obstacle_on_id is all-ones, else (obstacle_abs_pos_y + obstacle_on_id + anim_ofs) mod TEX_NUM, computed at PHY_WIDTH+1 bits with no overflow loss.
REQ-020 Stage 2 SHALL capture tex_idx, together with the tex_sel, valid and on flags carried through the pipeline.
REQ-021 Stage 3 SHALL register rgb = palette[tex_sel*2^COLOR_WIDTH + tex_idx] when on=1; when on=0 it SHALL register rgb=0 and rgb_hit=0.
REQ-022 rgb_valid SHALL equal pix_valid delayed 3 cycles; when valid=0, rgb and rgb_hit SHALL be 0.
REQ-023 Palette SHALL hold TEX_NUM*2^COLOR_WIDTH entries; a write SHALL take effect at the edge on which pal_we=1.
REQ-024 A stage-3 read of the address being written in the same cycle SHALL return the old value (read-first).
REQ-025 frame_cnt SHALL count frame_start pulses while anim_en=1; at ANIM_PERIOD-1 a pulse SHALL wrap it to 0 and increment anim_ofs mod TEX_NUM.
REQ-026 anim_en=0 SHALL hold frame_cnt and anim_ofs.
REQ-027 An anim_ofs change SHALL affect only requests entering stage 1 after the change; in-flight pixels SHALL keep their tex_sel.
REQ-028 frame_start coincident with pix_valid: the pixel SHALL use the pre-update anim_ofs.

Reset
REQ-029 sys_rst=1 SHALL immediately clear all pipeline registers, rgb, rgb_valid, rgb_hit, tex_sel, tex_addr, frame_cnt and anim_ofs to 0.
REQ-030 sys_rst SHALL reload every palette texture t with indices 0..3 = 12'h444, 12'h222, 12'h000, 12'h140.
REQ-031 Reset asserted mid-stream SHALL discard in-flight pixels; the first valid output after release SHALL appear 3 cycles after the first accepted request.

Verification
REQ-032 Scenario: face=01, x=3, y=7, abs_y=5, id=2, on=1, tex_idx=3 -> tex_addr=33, tex_sel=3, rgb=12'h140 at +3 cycles, hit=1.
REQ-033 Scenario: face=10, x=0, y=0 -> tex_addr=9; x=12 -> x_tex=W-1-2=7.
REQ-034 Scenario: id=4'hF, abs_y=7 -> tex_sel=0; on=0 -> rgb=0, hit=0, valid=1.
REQ-035 Scenario: anim_en=1, 30 frame_start pulses -> anim_ofs 0->1; after 120 pulses -> 0 (wrap).
REQ-036 Scenario: write pal_addr=5 data=12'hF00, then read tex_sel=1, idx=1 -> rgb=12'hF00; a same-cycle read returns 12'h222.
REQ-037 Scenario: sys_rst pulsed with 2 pixels in flight -> no rgb_valid for those pixels, and the palette returns to its defaults.
